// File: rtl/counter_pkg.sv
// Shared mode encodings and one-shot FSM state type for the mode counter.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } fsm_state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated clock divider: ticks once every prescale+1 enabled cycles.
module counter_prescaler #(
  parameter int unsigned prescale_width = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [prescale_width-1:0] prescale,
  output logic                      tick
);

  logic [prescale_width-1:0] cnt_q, cnt_d;

  // >= keeps the divider from running away if prescale shrinks mid-count.
  assign tick = enable && (cnt_q >= prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + prescale_width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot behaviour.
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned counter_width  = 32,
  parameter int unsigned prescale_width = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic [1:0]                mode,
  input  logic [counter_width-1:0]  modulus,
  input  logic [prescale_width-1:0] prescale,
  input  logic                      load,
  input  logic [counter_width-1:0]  load_value,
  input  logic                      start,
  output logic [counter_width-1:0]  result,
  output logic                      tc,
  output logic                      running,
  output logic                      done
);

  fsm_state_e               state_q, state_d;
  logic [counter_width-1:0] result_q, result_d;
  logic                     tc_q, tc_d;
  logic                     running_q, running_d;
  logic                     done_q, done_d;

  logic                     tick;
  logic                     is_oneshot, is_sat;
  logic                     at_term, run_ok, step, start_ok;
  logic [counter_width-1:0] term_val, preset, clamped, stepped;

  counter_prescaler #(
    .prescale_width(prescale_width)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (load),
    .prescale(prescale),
    .tick    (tick)
  );

  always_comb begin
    is_oneshot = (mode == MODE_ONESHOT);
    is_sat     = (mode == MODE_SAT);
    term_val   = up_down ? modulus : '0;
    // Preset value doubles as the wrap target: 0 going up, modulus going down.
    preset     = up_down ? '0 : modulus;
    at_term    = up_down ? (result_q >= modulus) : (result_q == '0);
    clamped    = (load_value > modulus) ? modulus : load_value;
    stepped    = up_down ? result_q + counter_width'(1) : result_q - counter_width'(1);
    // A leftover one-shot state blocks stepping for the one cycle it takes to drop to idle.
    run_ok     = is_oneshot ? (state_q == StRun) : (state_q == StIdle);
    step       = enable && tick && run_ok;
    start_ok   = is_oneshot && start && (state_q != StRun);

    result_d = result_q;
    state_d  = state_q;
    tc_d     = 1'b0;

    if (!is_oneshot) begin
      state_d = StIdle;
    end

    if (load) begin
      result_d = clamped;
      if (start_ok) begin
        state_d = StRun;
      end
    end else if (start_ok) begin
      result_d = preset;
      state_d  = StRun;
    end else if (step) begin
      if (at_term) begin
        if (is_oneshot) begin
          state_d = StDone;
          tc_d    = 1'b1;
        end else if (!is_sat) begin
          result_d = preset;
          tc_d     = (preset == term_val);
        end
      end else begin
        result_d = stepped;
        tc_d     = (stepped == term_val);
        if (is_oneshot && (stepped == term_val)) begin
          state_d = StDone;
        end
      end
    end

    running_d = is_oneshot ? (state_d == StRun) : enable;
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      tc_q      <= tc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign result  = result_q;
  assign tc      = tc_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed, table-driven bench for mode_counter with hand-computed expectations.
module tb_mode_counter;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          up_down;
  logic [1:0]    mode;
  logic [CW-1:0] modulus;
  logic [PW-1:0] prescale;
  logic          load;
  logic [CW-1:0] load_value;
  logic          start;
  logic [CW-1:0] result;
  logic          tc;
  logic          running;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mode_counter #(
    .counter_width (CW),
    .prescale_width(PW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .up_down   (up_down),
    .mode      (mode),
    .modulus   (modulus),
    .prescale  (prescale),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .result    (result),
    .tc        (tc),
    .running   (running),
    .done      (done)
  );

  typedef struct {
    string         nm;
    logic          ld;
    logic [CW-1:0] lv;
    logic          en;
    logic          up;
    logic [1:0]    md;
    logic [CW-1:0] mdl;
    logic [PW-1:0] ps;
    logic          st;
    logic [CW-1:0] e_res;
    logic          e_tc;
    logic          e_run;
    logic          e_done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic ld, int lv, logic en, logic up, logic [1:0] md,
                              int mdl, int ps, logic st, int e_res, logic e_tc, logic e_run,
                              logic e_done);
    vec_t v;
    v.nm = nm; v.ld = ld; v.lv = CW'(lv); v.en = en; v.up = up; v.md = md;
    v.mdl = CW'(mdl); v.ps = PW'(ps); v.st = st;
    v.e_res = CW'(e_res); v.e_tc = e_tc; v.e_run = e_run; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [CW-1:0] e_res, logic e_tc, logic e_run, logic e_done);
    chk({nm, ".result"}, 64'(result), 64'(e_res));
    chk({nm, ".tc"}, 64'(tc), 64'(e_tc));
    chk({nm, ".running"}, 64'(running), 64'(e_run));
    chk({nm, ".done"}, 64'(done), 64'(e_done));
  endtask

  task automatic apply(vec_t v);
    load = v.ld; load_value = v.lv; enable = v.en; up_down = v.up; mode = v.md;
    modulus = v.mdl; prescale = v.ps; start = v.st;
    @(posedge clk);
    #1;
    chk_all(v.nm, v.e_res, v.e_tc, v.e_run, v.e_done);
  endtask

  task automatic cyc(logic en, logic st, string nm, int e_res, logic e_tc, logic e_run,
                     logic e_done);
    enable = en; start = st;
    @(posedge clk);
    #1;
    chk_all(nm, CW'(e_res), e_tc, e_run, e_done);
  endtask

  initial begin
    // Wrap up, modulus 9: 1..9 (tc after reaching 9), then 0, 1.
    for (int i = 1; i <= 9; i++) vq.push_back(mk("wrap", 0, 0, 1, 1, 2'b00, 9, 0, 0, i, i == 9, 1, 0));
    vq.push_back(mk("wrap0", 0, 0, 1, 1, 2'b00, 9, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk("wrap1", 0, 0, 1, 1, 2'b00, 9, 0, 0, 1, 0, 1, 0));
    // Saturate down from a load of 3: single tc on reaching 0.
    vq.push_back(mk("sat_ld", 1, 3, 1, 0, 2'b01, 200, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk("sat2", 0, 0, 1, 0, 2'b01, 200, 0, 0, 2, 0, 1, 0));
    vq.push_back(mk("sat1", 0, 0, 1, 0, 2'b01, 200, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk("sat0", 0, 0, 1, 0, 2'b01, 200, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk("sat_hold_a", 0, 0, 1, 0, 2'b01, 200, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk("sat_hold_b", 0, 0, 1, 0, 2'b01, 200, 0, 0, 0, 0, 1, 0));
    // Clamped load, load beats a step, then wrap from terminal.
    vq.push_back(mk("ld_clamp", 1, 300, 1, 1, 2'b00, 250, 0, 0, 250, 0, 1, 0));
    vq.push_back(mk("ld_wrap", 0, 0, 1, 1, 2'b00, 250, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk("ld_wins", 1, 100, 1, 1, 2'b00, 250, 0, 0, 100, 0, 1, 0));
    vq.push_back(mk("ld_next", 0, 0, 1, 1, 2'b00, 250, 0, 0, 101, 0, 1, 0));
    // Prescale 3: a step every 4th enabled cycle, frozen while enable is low.
    vq.push_back(mk("ps_ld", 1, 0, 1, 1, 2'b00, 9, 3, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk("ps_wait", 0, 0, 1, 1, 2'b00, 9, 3, 0, 0, 0, 1, 0));
    vq.push_back(mk("ps_step", 0, 0, 1, 1, 2'b00, 9, 3, 0, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk("ps_off", 0, 0, 0, 1, 2'b00, 9, 3, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk("ps_wait2", 0, 0, 1, 1, 2'b00, 9, 3, 0, 1, 0, 1, 0));
    vq.push_back(mk("ps_step2", 0, 0, 1, 1, 2'b00, 9, 3, 0, 2, 0, 1, 0));
    // Modulus 0: held at 0, tc on every step.
    vq.push_back(mk("m0_ld", 1, 5, 1, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk("m0_a", 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk("m0_b", 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0));
    // One-shot up to 4, hold in DONE, restart.
    vq.push_back(mk("os_start", 0, 0, 1, 1, 2'b10, 4, 0, 1, 0, 0, 1, 0));
    for (int i = 1; i <= 3; i++) vq.push_back(mk("os_run", 0, 0, 1, 1, 2'b10, 4, 0, 0, i, 0, 1, 0));
    vq.push_back(mk("os_end", 0, 0, 1, 1, 2'b10, 4, 0, 0, 4, 1, 0, 1));
    vq.push_back(mk("os_hold_a", 0, 0, 1, 1, 2'b10, 4, 0, 0, 4, 0, 0, 1));
    vq.push_back(mk("os_hold_b", 0, 0, 1, 1, 2'b10, 4, 0, 0, 4, 0, 0, 1));
    vq.push_back(mk("os_restart", 0, 0, 1, 1, 2'b10, 4, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk("os_r1", 0, 0, 1, 1, 2'b10, 4, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk("os_r2", 0, 0, 1, 1, 2'b10, 4, 0, 0, 2, 0, 1, 0));
    // Leaving one-shot mid-run: one held cycle, then wrap stepping resumes.
    vq.push_back(mk("mchg_hold", 0, 0, 1, 1, 2'b00, 4, 0, 0, 2, 0, 1, 0));
    vq.push_back(mk("mchg_3", 0, 0, 1, 1, 2'b00, 4, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk("mchg_4", 0, 0, 1, 1, 2'b00, 4, 0, 0, 4, 1, 1, 0));
    // Load together with start enters RUN holding the loaded value.
    vq.push_back(mk("ldst", 1, 2, 1, 1, 2'b10, 4, 0, 1, 2, 0, 1, 0));
    vq.push_back(mk("ldst_3", 0, 0, 1, 1, 2'b10, 4, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk("ldst_4", 0, 0, 1, 1, 2'b10, 4, 0, 0, 4, 1, 0, 1));

    reset_n = 1'b0; enable = 1'b0; up_down = 1'b1; mode = 2'b00; modulus = '0;
    prescale = '0; load = 1'b0; load_value = '0; start = 1'b0;
    #23;
    chk_all("reset", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    // Asynchronous reset mid one-shot at result 7.
    load = 1'b0; up_down = 1'b1; mode = 2'b10; modulus = CW'(20); prescale = '0;
    cyc(1, 1, "rst_start", 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) cyc(1, 0, "rst_run", i, 0, 1, 0);
    reset_n = 1'b0;
    #2;
    chk_all("rst_async", '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, "rst_idle", 0, 0, 0, 0);
    cyc(1, 1, "rst_restart", 0, 0, 1, 0);
    cyc(1, 0, "rst_r1", 1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter counter_width, default 32, SHALL set the width of result, load_value and modulus (legal range 2..64).
REQ-002 Parameter prescale_width, default 8, SHALL set the width of prescale (legal range 1..16).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port enable  input  1  SHALL gate the prescaler and all count steps.
REQ-006 Port up_down  input  1  SHALL select direction: 1 = up, 0 = down.
REQ-007 Port mode  input  2  SHALL select behaviour: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (treated as wrap).
REQ-008 Port modulus  input  counter_width  SHALL give the top count value; the count range is 0..modulus inclusive.
REQ-009 Port prescale  input  prescale_width  SHALL give the divide ratio; one step per prescale+1 enabled cycles.
REQ-010 Port load / load_value  input  1 / counter_width  SHALL request a synchronous load of result.
REQ-011 Port start  input  1  SHALL arm a one-shot run; ignored in other modes.
REQ-012 Port result  output  counter_width  SHALL be the registered count.
REQ-013 Port tc  output  1  SHALL be a registered one-cycle terminal-count pulse.
REQ-014 Ports running / done  output  1 / 1  SHALL be registered status flags.

Function
REQ-015 The prescaler SHALL count enabled cycles 0..prescale and issue tick when it reaches prescale, then restart at 0; prescale = 0 SHALL tick every enabled cycle; enable low SHALL freeze the prescaler.
REQ-016 A step SHALL occur on a cycle with enable, tick and (mode != one-shot, or FSM in RUN).
REQ-017 The terminal value SHALL be modulus when counting up and 0 when counting down; result >= modulus SHALL count as terminal when counting up.
REQ-018 A non-terminal step SHALL add 1 (up) or subtract 1 (down), modulo 2^counter_width.
REQ-019 In wrap mode, a step at terminal SHALL set result to 0 (up) or modulus (down).
REQ-020 In saturate mode, a step at terminal SHALL leave result unchanged.
REQ-021 tc SHALL be 1 in the cycle after any step whose new result equals the terminal value, and 0 otherwise; in saturate mode, steps made while already at terminal SHALL NOT pulse tc.
REQ-022 The one-shot FSM SHALL have states IDLE, RUN and DONE; start in IDLE or DONE SHALL go to RUN and set result to 0 (up) or modulus (down); reaching terminal in RUN SHALL go to DONE.
REQ-023 running SHALL be 1 in RUN; in wrap/saturate modes running SHALL equal registered enable; done SHALL be 1 only in DONE.
REQ-024 A mode change away from one-shot SHALL force the FSM to IDLE on the next cycle, with result held.
REQ-025 load SHALL take priority over a step and over the start preset; the loaded value SHALL be min(load_value, modulus); load SHALL NOT change FSM state, except that load together with start SHALL enter RUN holding the loaded value.
REQ-026 A load SHALL reset the prescaler to 0; tc SHALL be 0 in the cycle after a load.
REQ-027 modulus = 0 SHALL hold result at 0, and every step SHALL pulse tc in wrap mode.

Reset
REQ-028 When reset_n is low, result SHALL be 0, tc SHALL be 0, running SHALL be 0, done SHALL be 0, the FSM SHALL be in IDLE and the prescaler SHALL be 0, all immediately and independent of clk.
REQ-029 Reset asserted mid-run SHALL abandon the run; after release the block SHALL require a new start in one-shot mode.

Structure
REQ-030 A shared package counter_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state typedef.
REQ-031 The prescaler SHALL be a sub-module counter_prescaler (ports clk, reset_n, enable, clear, prescale, tick).

Verification
REQ-032 Wrap: width 8, modulus 9, up, prescale 0, enable 1 -> result 0..9 then 0, with tc high one cycle after each transition to 9.
REQ-033 Saturate down: load 3, modulus 200 -> result 2, 1, 0, then holds at 0, with exactly one tc pulse.
REQ-034 Prescale 3, wrap up -> result increments every 4th enabled cycle; dropping enable for 5 cycles -> no step and no prescaler advance.
REQ-035 One-shot up, modulus 4, start pulse -> running 1, result 0..4, then done 1, running 0, result held at 4; a second start -> result 0 and RUN.
REQ-036 load_value 300 with modulus 250 -> result 250; load and step in the same cycle -> the load wins.
REQ-037 reset_n pulsed low mid one-shot at result 7 -> all outputs 0 and the FSM in IDLE asynchronously, with no count until the next start.
